dem_gio_phut_giay: RTL and testbench

//  Time-of-day counter downstream of the 1 Hz clock divider. Consumes the divider's square-wave output q as tick_in.

---
 rtl/dem_gio_phut_giay_if.sv | 24 ++
 rtl/dem_gio_phut_giay.sv | 203 ++++++++++++++++++++
 tb/tb_dem_gio_phut_giay.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dem_gio_phut_giay_if.sv
// Signal bundle between the time-of-day counter and its neighbours: conditioned
// inputs from the divider/buttons and the BCD time outputs for the display driver.
interface dem_gio_phut_giay_if;
    logic       tick_in;
    logic       btn_mode;
    logic       btn_inc;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic [7:0] hr_bcd;
    logic       pm;
    logic [1:0] set_mode;
    logic       sec_pulse;
    logic       day_carry;

    modport master (
        output tick_in, btn_mode, btn_inc,
        input  sec_bcd, min_bcd, hr_bcd, pm, set_mode, sec_pulse, day_carry
    );

    modport slave (
        input  tick_in, btn_mode, btn_inc,
        output sec_bcd, min_bcd, hr_bcd, pm, set_mode, sec_pulse, day_carry
    );
endinterface

// File: rtl/dem_gio_phut_giay.sv
// Time-of-day counter (packed BCD hh:mm:ss) with button-driven hour/minute set mode.
// Optional macro CLOCK_12H_EN: present hours as 01-12 with a PM flag (count stays 24 h).
module dem_gio_phut_giay #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] INIT_HR     = 8'h00,
    parameter logic [7:0] INIT_MIN    = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    dem_gio_phut_giay_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10
    } state_t;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end

    // Returns {wrapped, next}: increments a two-digit BCD value, wrapping at top.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top)
            return {1'b1, 8'h00};
        else if (v[3:0] == 4'd9)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    // ------------------------------------------------------------------
    // Input conditioning: synchronizer chain plus rising-edge detect
    // ------------------------------------------------------------------
    logic [2:0] raw;
    logic [2:0] rise;

    assign raw = {bus.btn_inc, bus.btn_mode, bus.tick_in};

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_sync
        logic [SYNC_STAGES-1:0] chain_reg;
        logic                   prev_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                chain_reg <= '0;
                prev_reg  <= 1'b0;
            end else begin
                chain_reg <= {chain_reg[SYNC_STAGES-2:0], raw[gi]};
                prev_reg  <= chain_reg[SYNC_STAGES-1];
            end
        end

        assign rise[gi] = chain_reg[SYNC_STAGES-1] & ~prev_reg;
    end

    logic tick_rise;
    logic mode_rise;
    logic inc_rise;

    assign tick_rise = rise[0];
    assign mode_rise = rise[1];
    assign inc_rise  = rise[2];

    // ------------------------------------------------------------------
    // Mode FSM and time registers
    // ------------------------------------------------------------------
    state_t     state_reg, state_next;
    logic [7:0] sec_reg, sec_next;
    logic [7:0] min_reg, min_next;
    logic [7:0] hr_reg, hr_next;
    logic       sec_pulse_reg, sec_pulse_next;
    logic       day_carry_reg, day_carry_next;

    logic [8:0] sec_inc;
    logic [8:0] min_inc;
    logic [8:0] hr_inc;

    assign sec_inc = bcd_inc(sec_reg, 8'h59);
    assign min_inc = bcd_inc(min_reg, 8'h59);
    assign hr_inc  = bcd_inc(hr_reg, 8'h23);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= ST_RUN;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next     = state_reg;
        sec_next       = sec_reg;
        min_next       = min_reg;
        hr_next        = hr_reg;
        sec_pulse_next = 1'b0;
        day_carry_next = 1'b0;

        case (state_reg)
            ST_RUN: begin
                // A tick coinciding with a mode press is still counted.
                if (tick_rise) begin
                    sec_pulse_next = 1'b1;
                    sec_next       = sec_inc[7:0];
                    if (sec_inc[8]) begin
                        min_next = min_inc[7:0];
                        if (min_inc[8]) begin
                            hr_next        = hr_inc[7:0];
                            day_carry_next = hr_inc[8];
                        end
                    end
                end
                if (mode_rise)
                    state_next = ST_SET_HR;
            end
            ST_SET_HR: begin
                if (mode_rise)
                    state_next = ST_SET_MIN;
                else if (inc_rise)
                    hr_next = hr_inc[7:0];
            end
            ST_SET_MIN: begin
                if (mode_rise) begin
                    state_next = ST_RUN;
                    sec_next   = 8'h00;
                end else if (inc_rise) begin
                    min_next = min_inc[7:0];
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_reg       <= 8'h00;
            min_reg       <= INIT_MIN;
            hr_reg        <= INIT_HR;
            sec_pulse_reg <= 1'b0;
            day_carry_reg <= 1'b0;
        end else begin
            sec_reg       <= sec_next;
            min_reg       <= min_next;
            hr_reg        <= hr_next;
            sec_pulse_reg <= sec_pulse_next;
            day_carry_reg <= day_carry_next;
        end
    end

    // ------------------------------------------------------------------
    // Hour presentation
    // ------------------------------------------------------------------
`ifdef CLOCK_12H_EN
    // Returns {pm, hr12} for a 24 h BCD hour.
    function automatic logic [8:0] hr_map(input logic [7:0] h);
        if (h == 8'h00)
            return {1'b0, 8'h12};
        else if (h < 8'h12)
            return {1'b0, h};
        else if (h == 8'h12)
            return {1'b1, 8'h12};
        else if (h[7:4] == 4'd1)
            return {1'b1, 4'h0, h[3:0] - 4'd2};
        else if (h[3:0] < 4'd2)
            return {1'b1, 4'h0, h[3:0] + 4'd8};
        else
            return {1'b1, 4'h1, h[3:0] - 4'd2};
    endfunction

    localparam logic [8:0] HR_RESET = hr_map(INIT_HR);

    logic [8:0] hr_map_next;
    logic [7:0] hr_out_reg;
    logic       pm_reg;

    assign hr_map_next = hr_map(hr_next);

    // Mapped from hr_next so the display hour changes on the same edge as the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hr_out_reg <= HR_RESET[7:0];
            pm_reg     <= HR_RESET[8];
        end else begin
            hr_out_reg <= hr_map_next[7:0];
            pm_reg     <= hr_map_next[8];
        end
    end

    assign bus.hr_bcd = hr_out_reg;
    assign bus.pm     = pm_reg;
`else
    assign bus.hr_bcd = hr_reg;
    assign bus.pm     = 1'b0;
`endif

    assign bus.sec_bcd   = sec_reg;
    assign bus.min_bcd   = min_reg;
    assign bus.set_mode  = state_reg;
    assign bus.sec_pulse = sec_pulse_reg;
    assign bus.day_carry = day_carry_reg;

endmodule

// File: tb/tb_dem_gio_phut_giay.sv
// Bench for dem_gio_phut_giay: directed scenarios plus random button/tick traffic,
// checked against a seconds-of-day reference model.
module tb_dem_gio_phut_giay;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dem_gio_phut_giay_if bus ();

    dem_gio_phut_giay #(
        .SYNC_STAGES(2),
        .INIT_HR    (8'h00),
        .INIT_MIN   (8'h00)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: time of day as integers, mode 0=run 1=set hour 2=set minute
    int m_hr   = 0;
    int m_min  = 0;
    int m_sec  = 0;
    int m_mode = 0;
    int exp_pulses  = 0;
    int exp_carries = 0;
    int obs_pulses  = 0;
    int obs_carries = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.sec_pulse) obs_pulses  = obs_pulses + 1;
            if (bus.day_carry) obs_carries = obs_carries + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic model_reset();
        m_hr = 0; m_min = 0; m_sec = 0; m_mode = 0;
    endtask

    task automatic model_event(input bit t, input bit m, input bit i);
        int s;
        if (m_mode == 0) begin
            if (t) begin
                s = m_hr * 3600 + m_min * 60 + m_sec + 1;
                exp_pulses++;
                if (s == 86400) begin
                    s = 0;
                    exp_carries++;
                end
                m_hr  = s / 3600;
                m_min = (s / 60) % 60;
                m_sec = s % 60;
            end
            if (m) m_mode = 1;
        end else if (m) begin
            if (m_mode == 2) m_sec = 0;
            m_mode = (m_mode + 1) % 3;
        end else if (i) begin
            if (m_mode == 1) m_hr  = (m_hr + 1) % 24;
            else             m_min = (m_min + 1) % 60;
        end
    endtask

    task automatic check_all(input string tag);
        int e_hr;
        int e_pm;
`ifdef CLOCK_12H_EN
        e_hr = (m_hr % 12 == 0) ? 12 : m_hr % 12;
        e_pm = (m_hr >= 12) ? 1 : 0;
`else
        e_hr = m_hr;
        e_pm = 0;
`endif
        chk({tag, ".sec"},   bus.sec_bcd,  to_bcd(m_sec));
        chk({tag, ".min"},   bus.min_bcd,  to_bcd(m_min));
        chk({tag, ".hr"},    bus.hr_bcd,   to_bcd(e_hr));
        chk({tag, ".pm"},    bus.pm,       e_pm);
        chk({tag, ".mode"},  bus.set_mode, m_mode);
        chk({tag, ".pulses"},  obs_pulses,  exp_pulses);
        chk({tag, ".carries"}, obs_carries, exp_carries);
    endtask

    // Drive a set of inputs high for 'hold' cycles, release, let it settle, update model.
    task automatic stim(input bit t, input bit m, input bit i, input int hold);
        @(negedge clk);
        bus.tick_in  = t;
        bus.btn_mode = m;
        bus.btn_inc  = i;
        repeat (hold) @(negedge clk);
        bus.tick_in  = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        repeat (4) @(negedge clk);
        model_event(t, m, i);
    endtask

    task automatic set_field_to(input int target_hr, input int target_min);
        stim(0, 1, 0, 2);
        while (m_hr != target_hr) stim(0, 0, 1, 2);
        stim(0, 1, 0, 2);
        while (m_min != target_min) stim(0, 0, 1, 2);
        stim(0, 1, 0, 2);
    endtask

    initial begin
        int r;
        int hold;
        bus.tick_in  = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;

        // Power-on reset
        repeat (3) @(negedge clk);
        model_reset();
        check_all("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Tick latency and single increment while held 1000 cycles
        bus.tick_in = 1'b1;
        @(negedge clk);
        chk("lat_e0.sec", bus.sec_bcd, 8'h00);
        @(negedge clk);
        chk("lat_e1.sec", bus.sec_bcd, 8'h00);
        chk("lat_e1.pulse", bus.sec_pulse, 1'b0);
        @(negedge clk);
        chk("lat_e2.sec", bus.sec_bcd, 8'h01);
        chk("lat_e2.pulse", bus.sec_pulse, 1'b1);
        @(negedge clk);
        chk("lat_e3.pulse", bus.sec_pulse, 1'b0);
        repeat (996) @(negedge clk);
        bus.tick_in = 1'b0;
        repeat (4) @(negedge clk);
        model_event(1, 0, 0);
        check_all("hold1000");

        // Set 23:59 then roll over the day
        set_field_to(23, 59);
        check_all("set2359");
        for (int k = 0; k < 59; k++) stim(1, 0, 0, 2);
        check_all("pre_roll");
        stim(1, 0, 0, 2);
        check_all("day_roll");

        // Hour wrap inside SET_HR and ticks ignored while setting
        stim(0, 1, 0, 2);
        while (m_hr != 23) stim(0, 0, 1, 1);
        check_all("sethr23");
        stim(0, 0, 1, 2);
        check_all("sethr_wrap");
        for (int k = 0; k < 5; k++) stim(1, 0, 0, 2);
        check_all("set_ticks");
        stim(0, 1, 0, 2);
        stim(0, 1, 0, 2);
        check_all("back_run");

        // Simultaneous events
        stim(0, 1, 1, 2);
        check_all("mode_inc");
        stim(0, 1, 0, 2);
        stim(0, 1, 0, 2);
        stim(1, 1, 0, 2);
        check_all("tick_mode");
        stim(0, 1, 0, 2);
        stim(0, 1, 0, 2);

        // Hour presentation at 12 and 13
        stim(0, 1, 0, 2);
        while (m_hr != 12) stim(0, 0, 1, 1);
        check_all("hr12");
        stim(0, 0, 1, 2);
        check_all("hr13");
        stim(0, 1, 0, 2);
        stim(0, 1, 0, 2);

        // Asynchronous reset mid-count at 12:34:56
        set_field_to(12, 34);
        for (int k = 0; k < 56; k++) stim(1, 0, 0, 1);
        check_all("t123456");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Random traffic
        for (int k = 0; k < 150; k++) begin
            r    = $urandom_range(0, 9);
            hold = $urandom_range(1, 4);
            case (r)
                5:       stim(0, 1, 0, hold);
                6:       stim(0, 0, 1, hold);
                7:       stim(1, 1, 0, hold);
                8:       stim(0, 1, 1, hold);
                9:       stim(1, 0, 1, hold);
                default: stim(1, 0, 0, hold);
            endcase
            check_all("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
